// File: rtl/sum_latch_uart_p.sv
// Two-operand add/subtract latch with a UART transmitter that serialises the
// registered result, least-significant byte first, as 8N1 frames.
module sum_latch_uart_p #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              save_a_n,
  input  logic              save_b_n,
  input  logic [DATA_W-1:0] data_input,
  input  logic              op_sub,
  input  logic              uart_tx_en,
  output logic [DATA_W:0]   result,
  output logic              uart_txd,
  output logic              uart_tx_busy,
  output logic              tx_done
);

  localparam int RES_W  = DATA_W + 1;
  localparam int NBYTES = (RES_W + 7) / 8;
  localparam int BUF_W  = NBYTES * 8;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // Carry/borrow lands in the MSB; subtraction wraps modulo 2^RES_W.
  function automatic logic [RES_W-1:0] add_sub(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic              sub);
    logic [RES_W-1:0] ax;
    logic [RES_W-1:0] bx;
    ax = {1'b0, a};
    bx = {1'b0, b};
    return sub ? (ax - bx) : (ax + bx);
  endfunction

  logic [DATA_W-1:0] a_p0;
  logic [DATA_W-1:0] b_p0;
  logic [RES_W-1:0]  result_p1;

  // Stage p0: operand capture
  always_ff @(posedge clk) begin
    if (reset) begin
      a_p0 <= '0;
      b_p0 <= '0;
    end else begin
      if (!save_a_n) a_p0 <= data_input;
      if (!save_b_n) b_p0 <= data_input;
    end
  end

  // Stage p1: arithmetic result
  always_ff @(posedge clk) begin
    if (reset) result_p1 <= '0;
    else       result_p1 <= add_sub(a_p0, b_p0, op_sub);
  end

  assign result = result_p1;

  tx_state_t         state, state_n;
  logic [CNT_W-1:0]  baud_cnt, baud_cnt_n;
  logic [2:0]        bit_idx, bit_idx_n;
  logic [BYTE_W-1:0] byte_idx, byte_idx_n;
  logic [BUF_W-1:0]  shreg, shreg_n;
  logic              txd_n;
  logic              busy_n;
  logic              done_n;
  logic              bit_tick;

  assign bit_tick = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // The shift buffer moves right after every data bit, so bit 0 is always
  // the next bit on the line and each new byte arrives at the bottom.
  always_comb begin
    state_n    = state;
    baud_cnt_n = bit_tick ? '0 : baud_cnt + CNT_W'(1);
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    shreg_n    = shreg;
    done_n     = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_n = '0;
        if (uart_tx_en) begin
          shreg_n    = BUF_W'(result_p1);
          byte_idx_n = '0;
          bit_idx_n  = '0;
          state_n    = START;
        end
      end
      START: begin
        if (bit_tick) begin
          bit_idx_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shreg_n = shreg >> 1;
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (byte_idx == BYTE_W'(NBYTES - 1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            byte_idx_n = byte_idx + BYTE_W'(1);
            state_n    = START;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shreg_n[0];
      default: txd_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE);
  end

  // Line outputs are registered alongside the state so they never glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      bit_idx      <= '0;
      byte_idx     <= '0;
      shreg        <= '0;
      uart_txd     <= 1'b1;
      uart_tx_busy <= 1'b0;
      tx_done      <= 1'b0;
    end else begin
      state        <= state_n;
      baud_cnt     <= baud_cnt_n;
      bit_idx      <= bit_idx_n;
      byte_idx     <= byte_idx_n;
      shreg        <= shreg_n;
      uart_txd     <= txd_n;
      uart_tx_busy <= busy_n;
      tx_done      <= done_n;
    end
  end

endmodule

// File: tb/tb_sum_latch_uart_p.sv
// Bench for sum_latch_uart_p: an 8-bit instance checked cycle by cycle against
// a frame-level model, plus a 15-bit instance checked with literal values.
module tb_sum_latch_uart_p;

  localparam int CPB = 4;
  localparam int TOT = 2 * 10 * CPB;

  logic clk;
  logic rst1, sa1, sb1, sub1, en1;
  logic [7:0] d1;
  logic [8:0] result1;
  logic txd1, busy1, done1;
  logic rst2, sa2, sb2, sub2, en2;
  logic [14:0] d2;
  logic [15:0] result2;
  logic txd2, busy2, done2;

  sum_latch_uart_p #(.DATA_W(8), .CLKS_PER_BIT(CPB)) dut1 (
    .clk(clk), .reset(rst1), .save_a_n(sa1), .save_b_n(sb1), .data_input(d1),
    .op_sub(sub1), .uart_tx_en(en1), .result(result1), .uart_txd(txd1),
    .uart_tx_busy(busy1), .tx_done(done1));

  sum_latch_uart_p #(.DATA_W(15), .CLKS_PER_BIT(CPB)) dut2 (
    .clk(clk), .reset(rst2), .save_a_n(sa2), .save_b_n(sb2), .data_input(d2),
    .op_sub(sub2), .uart_tx_en(en2), .result(result2), .uart_txd(txd2),
    .uart_tx_busy(busy2), .tx_done(done2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level model: operands, result and a precomputed line waveform that is
  // played out one sample per cycle while remaining cycles are non-zero.
  logic [7:0]  a_m, b_m;
  logic [8:0]  res_m;
  logic [0:TOT-1] wave_m;
  int          rem_m, pos_m;
  logic        done_m;

  function automatic logic [0:TOT-1] make_wave(input logic [8:0] r);
    logic [0:TOT-1] w;
    logic [15:0] v;
    logic b;
    v = 16'(r);
    w = '0;
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 10; j++) begin
        if (j == 0)      b = 1'b0;
        else if (j == 9) b = 1'b1;
        else             b = v[k*8 + j - 1];
        for (int c = 0; c < CPB; c++) w[(k*10 + j)*CPB + c] = b;
      end
    return w;
  endfunction

  always @(posedge clk) begin
    if (rst1) begin
      a_m <= '0; b_m <= '0; res_m <= '0;
      rem_m <= 0; pos_m <= 0; done_m <= 1'b0;
    end else begin
      res_m <= sub1 ? ({1'b0, a_m} - {1'b0, b_m}) : ({1'b0, a_m} + {1'b0, b_m});
      if (!sa1) a_m <= d1;
      if (!sb1) b_m <= d1;
      done_m <= 1'b0;
      if (rem_m > 0) begin
        rem_m <= rem_m - 1;
        pos_m <= pos_m + 1;
        if (rem_m == 1) done_m <= 1'b1;
      end else if (en1) begin
        wave_m <= make_wave(res_m);
        rem_m  <= TOT;
        pos_m  <= 0;
      end
    end
  end

  int checks, errors;
  int busy_cnt1, done_cnt1, busy_cnt2, done_cnt2;
  int bsnap, dsnap, n;
  logic chk_en;
  logic exp_txd;
  logic [7:0] v0, v1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic line(input int sel);
    return (sel == 1) ? txd2 : txd1;
  endfunction

  task automatic rx_byte(input int sel, output logic [7:0] v);
    int w;
    w = 0;
    v = '0;
    while (line(sel) !== 1'b0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (w >= 300) begin
      errors++;
      $display("FAIL rx_start_timeout: waited %0d cycles, limit 300", w);
    end
    repeat (5) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      v[i] = line(sel);
      if (i < 7) repeat (CPB) @(negedge clk);
    end
    repeat (CPB) @(negedge clk);
    chk("stop_bit", 32'(line(sel)), 32'd1);
  endtask

  task automatic pulse_en1;
    en1 = 1'b1;
    @(negedge clk);
    en1 = 1'b0;
  endtask

  task automatic load1(input logic [7:0] a, input logic [7:0] b);
    d1 = a; sa1 = 1'b0;
    @(negedge clk);
    sa1 = 1'b1; d1 = b; sb1 = 1'b0;
    @(negedge clk);
    sb1 = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send1(input logic [7:0] e0, input logic [7:0] e1);
    bsnap = busy_cnt1;
    dsnap = done_cnt1;
    pulse_en1();
    rx_byte(0, v0);
    chk("byte0", 32'(v0), 32'(e0));
    rx_byte(0, v1);
    chk("byte1", 32'(v1), 32'(e1));
    repeat (6) @(negedge clk);
    chk("busy_cycles", 32'(busy_cnt1 - bsnap), 32'(TOT));
    chk("done_pulses", 32'(done_cnt1 - dsnap), 32'd1);
  endtask

  initial begin
    rst1 = 1'b1; sa1 = 1'b1; sb1 = 1'b1; d1 = '0; sub1 = 1'b0; en1 = 1'b0;
    rst2 = 1'b1; sa2 = 1'b1; sb2 = 1'b1; d2 = '0; sub2 = 1'b0; en2 = 1'b0;
    chk_en = 1'b0; checks = 0; errors = 0;
    busy_cnt1 = 0; done_cnt1 = 0; busy_cnt2 = 0; done_cnt2 = 0;

    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          busy_cnt1 += int'(busy1);
          done_cnt1 += int'(done1);
          busy_cnt2 += int'(busy2);
          done_cnt2 += int'(done2);
          exp_txd = (rem_m > 0) ? wave_m[pos_m] : 1'b1;
          chk("model_result", 32'(result1), 32'(res_m));
          chk("model_txd", 32'(txd1), 32'(exp_txd));
          chk("model_busy", 32'(busy1), 32'(rem_m > 0));
          chk("model_tx_done", 32'(done1), 32'(done_m));
        end
      end
    join_none

    repeat (3) @(negedge clk);
    rst1 = 1'b0; rst2 = 1'b0; chk_en = 1'b1;
    chk("reset_result", 32'(result1), 32'd0);
    chk("reset_txd", 32'(txd1), 32'd1);
    chk("reset_busy", 32'(busy1), 32'd0);
    chk("reset_done", 32'(done1), 32'd0);
    chk("reset_result2", 32'(result2), 32'd0);

    // 200 + 100
    load1(8'd200, 8'd100);
    chk("add_result", 32'(result1), 32'h12C);
    send1(8'h2C, 8'h01);

    // 5 - 7 wraps with borrow
    sub1 = 1'b1;
    load1(8'd5, 8'd7);
    chk("sub_result", 32'(result1), 32'h1FE);
    send1(8'hFE, 8'h01);

    // Both strobes in one cycle
    sub1 = 1'b0;
    d1 = 8'h33; sa1 = 1'b0; sb1 = 1'b0;
    @(negedge clk);
    sa1 = 1'b1; sb1 = 1'b1;
    repeat (2) @(negedge clk);
    chk("both_add", 32'(result1), 32'h066);
    sub1 = 1'b1;
    repeat (2) @(negedge clk);
    chk("both_sub", 32'(result1), 32'h000);
    sub1 = 1'b0;
    repeat (2) @(negedge clk);

    // Mid-frame operand change and re-requests
    bsnap = busy_cnt1;
    dsnap = done_cnt1;
    pulse_en1();
    fork
      begin
        rx_byte(0, v0);
        rx_byte(0, v1);
      end
      begin
        repeat (10) @(negedge clk);
        d1 = 8'hFF; sa1 = 1'b0;
        @(negedge clk);
        sa1 = 1'b1; en1 = 1'b1;
        @(negedge clk);
        en1 = 1'b0;
        repeat (40) @(negedge clk);
        en1 = 1'b1;
        @(negedge clk);
        en1 = 1'b0;
      end
    join
    chk("inflight_byte0", 32'(v0), 32'h66);
    chk("inflight_byte1", 32'(v1), 32'h00);
    repeat (6) @(negedge clk);
    chk("inflight_busy_cycles", 32'(busy_cnt1 - bsnap), 32'(TOT));
    chk("inflight_done_pulses", 32'(done_cnt1 - dsnap), 32'd1);
    chk("changed_result", 32'(result1), 32'h132);

    // Held request restarts right after tx_done
    en1 = 1'b1;
    n = 0;
    while (done1 !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("held_done_seen", 32'(n < 400), 32'd1);
    @(negedge clk);
    chk("held_restart_busy", 32'(busy1), 32'd1);
    en1 = 1'b0;
    repeat (90) @(negedge clk);
    chk("held_idle_after", 32'(busy1), 32'd0);

    // Reset during DATA of byte 0, with competing strobes
    dsnap = done_cnt1;
    pulse_en1();
    repeat (8) @(negedge clk);
    rst1 = 1'b1; sa1 = 1'b0; d1 = 8'h55; en1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0; sa1 = 1'b1; en1 = 1'b0;
    chk("abort_txd", 32'(txd1), 32'd1);
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_result", 32'(result1), 32'd0);
    repeat (2) @(negedge clk);
    chk("abort_a_not_loaded", 32'(result1), 32'd0);
    repeat (100) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt1 - dsnap), 32'd0);

    // 15-bit instance: 0x7FFF + 0x7FFF
    d2 = 15'h7FFF; sa2 = 1'b0; sb2 = 1'b0;
    @(negedge clk);
    sa2 = 1'b1; sb2 = 1'b1;
    repeat (2) @(negedge clk);
    chk("w15_result", 32'(result2), 32'hFFFE);
    bsnap = busy_cnt2;
    dsnap = done_cnt2;
    en2 = 1'b1;
    @(negedge clk);
    en2 = 1'b0;
    rx_byte(1, v0);
    chk("w15_byte0", 32'(v0), 32'hFE);
    rx_byte(1, v1);
    chk("w15_byte1", 32'(v1), 32'hFF);
    repeat (6) @(negedge clk);
    chk("w15_busy_cycles", 32'(busy_cnt2 - bsnap), 32'(TOT));
    chk("w15_done_pulses", 32'(done_cnt2 - dsnap), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded 200000");
    $fatal(1, "watchdog");
  end

endmodule
